// File: rtl/controle_medicao_hcsr04_if.sv
// Signal bundle between the measurement scheduler and its surroundings:
// the enable from top-level control, the HC-SR04 interface handshake and
// the published results / debug state.
interface controle_medicao_hcsr04_if;
  logic        ligar;
  logic        pronto;
  logic [11:0] medida;
  logic        medir;
  logic        zera_sensor;
  logic [11:0] media;
  logic        nova_media;
  logic [3:0]  falhas;
  logic [3:0]  db_estado;

  // Scheduler side
  modport master (
    input  ligar, pronto, medida,
    output medir, zera_sensor, media, nova_media, falhas, db_estado
  );

  // Environment side (top-level control plus sensor interface)
  modport slave (
    output ligar, pronto, medida,
    input  medir, zera_sensor, media, nova_media, falhas, db_estado
  );
endinterface

// File: rtl/controle_medicao_hcsr04.sv
// HC-SR04 measurement scheduler: fires a one-cycle medir every PERIODO
// cycles while enabled, waits for pronto up to TIMEOUT cycles, aborts the
// sensor interface on timeout and publishes the truncated mean of every
// four accepted distances.
module controle_medicao_hcsr04 #(
  parameter int PERIODO = 3000000,
  parameter int TIMEOUT = 1500000
) (
  input  logic                       clock,
  input  logic                       reset,
  controle_medicao_hcsr04_if.master  bus
);

  localparam int TW = (PERIODO > 2) ? $clog2(PERIODO) : 2;
  // Last espera cycle before the measurement is declared lost.
  localparam logic [TW-1:0] LIMITE_ESPERA = TW'(TIMEOUT - 1);
  // tempo is 0 in the cycle after dispara, so leaving intervalo when it
  // reads PERIODO-2 puts the next dispara exactly PERIODO cycles later.
  localparam logic [TW-1:0] FIM_INTERVALO = TW'(PERIODO - 2);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    DISPARA   = 3'd1,
    ESPERA    = 3'd2,
    PUBLICA   = 3'd3,
    FALHA     = 3'd4,
    INTERVALO = 3'd5
  } estado_t;

  estado_t        estado_reg, estado_next;
  logic [1:0]     cnt_reg, cnt_next;
  logic [13:0]    acc_reg, acc_next;
  logic [TW-1:0]  tempo_reg, tempo_next;
  logic [11:0]    media_reg, media_next;
  logic [3:0]     falhas_reg, falhas_next;

  logic [13:0]    soma;
  logic [TW-1:0]  tempo_inc;
  logic           aborta;

  assign soma      = acc_reg + {2'b00, bus.medida};
  assign tempo_inc = tempo_reg + TW'(1);
  // Dropping the enable anywhere but ocioso abandons the current batch.
  assign aborta    = !bus.ligar && (estado_reg != OCIOSO);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg <= OCIOSO;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // Datapath registers: sample count, accumulator, shared timer, results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg    <= 2'd0;
      acc_reg    <= 14'd0;
      tempo_reg  <= '0;
      media_reg  <= 12'd0;
      falhas_reg <= 4'd0;
    end else begin
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      tempo_reg  <= tempo_next;
      media_reg  <= media_next;
      falhas_reg <= falhas_next;
    end
  end

  // Next-state and datapath update; the enable drop overrides everything
  always_comb begin
    estado_next = estado_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    tempo_next  = tempo_reg;
    media_next  = media_reg;
    falhas_next = falhas_reg;

    case (estado_reg)
      OCIOSO: begin
        cnt_next   = 2'd0;
        acc_next   = 14'd0;
        tempo_next = '0;
        if (bus.ligar) estado_next = DISPARA;
      end
      DISPARA: begin
        tempo_next  = '0;
        estado_next = ESPERA;
      end
      ESPERA: begin
        tempo_next = tempo_inc;
        // pronto is checked first so it beats a simultaneous timeout
        if (bus.pronto) begin
          if (cnt_reg == 2'd3) begin
            media_next  = soma[13:2];
            acc_next    = 14'd0;
            cnt_next    = 2'd0;
            estado_next = PUBLICA;
          end else begin
            acc_next    = soma;
            cnt_next    = cnt_reg + 2'd1;
            estado_next = INTERVALO;
          end
        end else if (tempo_reg == LIMITE_ESPERA) begin
          estado_next = FALHA;
        end
      end
      FALHA: begin
        tempo_next = tempo_inc;
        if (falhas_reg != 4'd15) falhas_next = falhas_reg + 4'd1;
        estado_next = INTERVALO;
      end
      PUBLICA: begin
        tempo_next  = tempo_inc;
        estado_next = INTERVALO;
      end
      INTERVALO: begin
        tempo_next = tempo_inc;
        if (tempo_reg == FIM_INTERVALO) estado_next = DISPARA;
      end
      default: estado_next = OCIOSO;
    endcase

    if (aborta) begin
      estado_next = OCIOSO;
      cnt_next    = 2'd0;
      acc_next    = 14'd0;
      tempo_next  = '0;
      media_next  = media_reg;
    end
  end

  // Moore strobes, plus the abort of an in-flight measurement on enable drop
  assign bus.medir       = (estado_reg == DISPARA);
  assign bus.nova_media  = (estado_reg == PUBLICA);
  assign bus.zera_sensor = (estado_reg == FALHA) ||
                           ((estado_reg == ESPERA) && !bus.ligar);
  assign bus.media       = media_reg;
  assign bus.falhas      = falhas_reg;
  assign bus.db_estado   = {1'b0, estado_reg};

endmodule
